// File: rtl/dmux_nway_buf.sv
// -----------------------------------------------------------------------------
// dmux_nway_buf
//   Registered 1-to-N demultiplexer with a one-entry holding slot per output
//   channel. A word is accepted from a single producer and, one cycle later,
//   presented on the addressed channel (or on every channel in broadcast
//   mode). A stalled consumer only backpressures words addressed to it.
//
// Parameters
//   WIDTH  data word width in bits
//   SEL_W  select width; channel count N = 2**SEL_W
//   CNT_W  width of the wrapping accepted-transfer counter
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous reset, active-low
//   in_data     input word
//   in_sel      destination channel index (ignored when in_bcast=1)
//   in_bcast    1 = deliver the word to all N channels
//   in_valid    producer has a word
//   in_ready    block accepts a word this cycle (combinational)
//   out_data    flat bus, channel i = bits [i*WIDTH +: WIDTH]
//   out_valid   slot i holds a word
//   out_ready   consumer i takes its word this cycle
//   xfer_count  number of accepted input transfers (broadcast counts once)
// -----------------------------------------------------------------------------
module dmux_nway_buf #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_bcast,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [(2**SEL_W)*WIDTH-1:0] out_data,
  output logic [(2**SEL_W)-1:0]       out_valid,
  input  logic [(2**SEL_W)-1:0]       out_ready,
  output logic [CNT_W-1:0]            xfer_count
);

  localparam int N = 2**SEL_W;

  logic [N-1:0]     free;
  logic [N-1:0]     load;
  logic             accept;

  logic [N-1:0]     out_valid_q;
  logic [N-1:0]     out_valid_d;
  logic [WIDTH-1:0] data_q [N];
  logic [WIDTH-1:0] data_d [N];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A slot can take a new word when it is empty or is being drained this
  // cycle, which is what makes back-to-back streaming run at full rate.
  // This leaves a combinational path out_ready -> in_ready.
  assign free = ~out_valid_q | out_ready;

  // in_ready is held low during reset and never looks at in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      if (in_bcast) in_ready = &free;
      else          in_ready = free[in_sel];
    end
  end

  assign accept = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign load[gi] = accept & (in_bcast | (in_sel == SEL_W'(gi)));

      // Load wins over a same-cycle drain; an unloaded slice keeps its old
      // value even after draining, consumers qualify it with out_valid.
      always_comb begin
        out_valid_d[gi] = out_valid_q[gi] & ~out_ready[gi];
        data_d[gi]      = data_q[gi];
        if (load[gi]) begin
          out_valid_d[gi] = 1'b1;
          data_d[gi]      = in_data;
        end
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          out_valid_q[gi] <= 1'b0;
          data_q[gi]      <= '0;
        end else begin
          out_valid_q[gi] <= out_valid_d[gi];
          data_q[gi]      <= data_d[gi];
        end
      end

      assign out_data[gi*WIDTH +: WIDTH] = data_q[gi];
    end
  endgenerate

  // Counter wraps naturally modulo 2**CNT_W.
  always_comb begin
    count_d = count_q + CNT_W'(accept);
  end

  always_ff @(posedge clock) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign out_valid  = out_valid_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_dmux_nway_buf.sv
// -----------------------------------------------------------------------------
// tb_dmux_nway_buf
//   Directed self-checking bench for dmux_nway_buf. Two instances share all
//   inputs: the default one (CNT_W=16) and a narrow-counter one (CNT_W=4)
//   used to observe counter wrap. Inputs change 1 ns after a rising edge,
//   outputs are sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_dmux_nway_buf;

  localparam int WIDTH = 16;
  localparam int SEL_W = 3;
  localparam int N     = 8;

  logic              clock;
  logic              reset;
  logic [WIDTH-1:0]  in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_bcast;
  logic              in_valid;
  logic              in_ready;
  logic              in_ready4;
  logic [N*WIDTH-1:0] out_data;
  logic [N*WIDTH-1:0] out_data4;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_valid4;
  logic [N-1:0]      out_ready;
  logic [15:0]       xfer_count;
  logic [3:0]        xfer_count4;

  int compared;
  int mismatched;

  dmux_nway_buf #(.WIDTH(16), .SEL_W(3), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count)
  );

  dmux_nway_buf #(.WIDTH(16), .SEL_W(3), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .xfer_count(xfer_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] slice(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  // Drain everything with no new input.
  task automatic idle();
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = 8'hFF;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_sel = 3'd0; in_data = 16'hDEAD;
    in_bcast = 1'b0; out_ready = 8'hFF;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    tick(); tick();
    compared++;
    if (out_valid !== 8'h00) begin
      mismatched++; $display("FAIL reset_out_valid: got %h want 00", out_valid);
    end
    compared++;
    if (out_data !== '0) begin
      mismatched++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    compared++;
    if (xfer_count !== 16'd0) begin
      mismatched++; $display("FAIL reset_xfer_count: got %0d want 0", xfer_count);
    end
    reset = 1'b1; in_valid = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_unicast();
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_sel = 3'(i); in_data = 16'hA000 + 16'(i);
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++; $display("FAIL uni_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      $display("unicast sel=%0d data=%h", i, 16'hA000 + 16'(i));
      compared++;
      if (out_valid !== 8'(1 << i)) begin
        mismatched++;
        $display("FAIL uni_out_valid[%0d]: got %h want %h", i, out_valid, 8'(1 << i));
      end
      compared++;
      if (slice(i) !== 16'hA000 + 16'(i)) begin
        mismatched++;
        $display("FAIL uni_data[%0d]: got %h want %h", i, slice(i), 16'hA000 + 16'(i));
      end
    end
    in_valid = 1'b0;
    compared++;
    if (xfer_count !== 16'd8) begin
      mismatched++; $display("FAIL uni_xfer_count: got %0d want 8", xfer_count);
    end
  endtask

  task automatic test_backpressure();
    idle();
    out_ready = 8'hF7;  // channel 3 stalled
    in_valid = 1'b1; in_sel = 3'd3; in_data = 16'h1111;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL bp_first_ready: got %b want 1", in_ready);
    end
    tick();
    $display("unicast sel=3 data=1111");
    in_data = 16'h2222;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++; $display("FAIL bp_stall_ready: got %b want 0", in_ready);
    end
    tick();
    compared++;
    if (slice(3) !== 16'h1111 || out_valid[3] !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_hold3: got %h/%b want 1111/1", slice(3), out_valid[3]);
    end
    in_sel = 3'd5; in_data = 16'h3333;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL bp_other_ready: got %b want 1", in_ready);
    end
    tick();
    $display("unicast sel=5 data=3333");
    compared++;
    if (slice(5) !== 16'h3333 || out_valid[5] !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_chan5: got %h/%b want 3333/1", slice(5), out_valid[5]);
    end
    // Release channel 3: 1111 drains while 2222 loads on the same edge.
    out_ready = 8'hFF; in_sel = 3'd3; in_data = 16'h2222;
    #1;
    compared++;
    if (in_ready !== 1'b1 || slice(3) !== 16'h1111) begin
      mismatched++;
      $display("FAIL bp_release: got ready=%b data=%h want 1/1111", in_ready, slice(3));
    end
    tick();
    $display("unicast sel=3 data=2222");
    in_valid = 1'b0;
    compared++;
    if (slice(3) !== 16'h2222 || out_valid[3] !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_second3: got %h/%b want 2222/1", slice(3), out_valid[3]);
    end
    compared++;
    if (xfer_count !== 16'd11) begin
      mismatched++; $display("FAIL bp_xfer_count: got %0d want 11", xfer_count);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    in_valid = 1'b1; in_sel = 3'd2;
    for (int k = 0; k < 10; k++) begin
      in_data = 16'h4000 + 16'(k);
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready);
      end
      tick();
      $display("stream sel=2 data=%h", 16'h4000 + 16'(k));
      compared++;
      if (out_valid[2] !== 1'b1 || slice(2) !== 16'h4000 + 16'(k)) begin
        mismatched++;
        $display("FAIL b2b_out[%0d]: got %b/%h want 1/%h", k, out_valid[2], slice(2),
                 16'h4000 + 16'(k));
      end
    end
    in_valid = 1'b0;
    // 11 earlier accepts + 10 streamed words.
    compared++;
    if (xfer_count !== 16'd21) begin
      mismatched++; $display("FAIL b2b_xfer_count: got %0d want 21", xfer_count);
    end
  endtask

  task automatic test_broadcast();
    idle();
    out_ready = 8'hBF;  // channel 6 stalled
    in_valid = 1'b1; in_sel = 3'd6; in_data = 16'h6666;
    tick();
    $display("unicast sel=6 data=6666");
    in_bcast = 1'b1; in_sel = 3'd1; in_data = 16'hBEEF;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++; $display("FAIL bc_blocked_ready: got %b want 0", in_ready);
    end
    tick();
    compared++;
    if (xfer_count !== 16'd22 || slice(6) !== 16'h6666) begin
      mismatched++;
      $display("FAIL bc_blocked_state: got cnt=%0d d6=%h want 22/6666", xfer_count, slice(6));
    end
    out_ready = 8'hFF;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL bc_ready: got %b want 1", in_ready);
    end
    tick();
    $display("broadcast data=BEEF");
    in_valid = 1'b0; in_bcast = 1'b0;
    compared++;
    if (out_valid !== 8'hFF) begin
      mismatched++; $display("FAIL bc_out_valid: got %h want FF", out_valid);
    end
    for (int i = 0; i < N; i++) begin
      compared++;
      if (slice(i) !== 16'hBEEF) begin
        mismatched++; $display("FAIL bc_data[%0d]: got %h want BEEF", i, slice(i));
      end
    end
    compared++;
    if (xfer_count !== 16'd23) begin
      mismatched++; $display("FAIL bc_xfer_count: got %0d want 23", xfer_count);
    end
  endtask

  task automatic test_reset_and_wrap();
    idle();
    out_ready = 8'h00;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sel = 3'(i); in_data = 16'h0001 + 16'(i);
      tick();
      $display("unicast sel=%0d data=%h", i, 16'h0001 + 16'(i));
    end
    compared++;
    if (out_valid !== 8'h07) begin
      mismatched++; $display("FAIL mid_preload: got %h want 07", out_valid);
    end
    reset = 1'b0; in_sel = 3'd4; in_data = 16'h7777;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++; $display("FAIL mid_reset_ready: got %b want 0", in_ready);
    end
    tick();
    reset = 1'b1; in_valid = 1'b0;
    compared++;
    if (out_valid !== 8'h00 || out_data !== '0 || xfer_count !== 16'd0) begin
      mismatched++;
      $display("FAIL mid_reset_clear: got v=%h d=%h c=%0d want 00/0/0",
               out_valid, out_data, xfer_count);
    end
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    for (int k = 0; k < 17; k++) begin
      in_sel = 3'(k % 8); in_data = 16'h5000 + 16'(k);
      tick();
      $display("wrap accept %0d sel=%0d", k, k % 8);
    end
    in_valid = 1'b0;
    compared++;
    if (xfer_count4 !== 4'd1) begin
      mismatched++; $display("FAIL wrap_count4: got %0d want 1", xfer_count4);
    end
    compared++;
    if (xfer_count !== 16'd17) begin
      mismatched++; $display("FAIL wrap_count16: got %0d want 17", xfer_count);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    in_data    = '0;
    in_sel     = '0;
    in_bcast   = 1'b0;
    in_valid   = 1'b0;
    out_ready  = '0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_back_to_back();
    test_broadcast();
    test_reset_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
